// File: rtl/systolic_pq_if.sv
// -----------------------------------------------------------------------------
// systolic_pq_if
// Operation request / head status bundle for the systolic priority queue.
//   i_op_valid : operation request, taken when o_ready is high
//   i_op       : 00 ENQUEUE, 01 DEQUEUE, 10 REPLACE, 11 NOP
//   i_key      : key for ENQUEUE / REPLACE
//   i_val      : payload for ENQUEUE / REPLACE
//   o_ready    : an operation can be accepted this cycle
//   o_key      : head key
//   o_val      : head payload
//   o_count    : number of stored entries
//   o_full     : queue full
//   o_empty    : queue empty
//   o_drop     : one-cycle pulse, an accepted operation was discarded
// master drives requests (user side), slave is the queue.
// -----------------------------------------------------------------------------
interface systolic_pq_if #(
  parameter int KEY_WIDTH = 16,
  parameter int VAL_WIDTH = 16,
  parameter int CNT_WIDTH = 5
);
  logic                 i_op_valid;
  logic [1:0]           i_op;
  logic [KEY_WIDTH-1:0] i_key;
  logic [VAL_WIDTH-1:0] i_val;
  logic                 o_ready;
  logic [KEY_WIDTH-1:0] o_key;
  logic [VAL_WIDTH-1:0] o_val;
  logic [CNT_WIDTH-1:0] o_count;
  logic                 o_full;
  logic                 o_empty;
  logic                 o_drop;

  modport master (
    output i_op_valid, i_op, i_key, i_val,
    input  o_ready, o_key, o_val, o_count, o_full, o_empty, o_drop
  );

  modport slave (
    input  i_op_valid, i_op, i_key, i_val,
    output o_ready, o_key, o_val, o_count, o_full, o_empty, o_drop
  );
endinterface

// File: rtl/systolic_pq.sv
// -----------------------------------------------------------------------------
// systolic_pq
// Systolic priority queue: a linear array of QUEUE_SIZE cells, cell 0 is the
// head. An accepted operation is applied to cell 0 on the accepting edge and
// then travels toward the tail as a token, one cell per cycle. Operations are
// spaced at least two cycles apart, so consecutive tokens are always two cells
// apart and a cell only ever looks at its lower neighbour after that
// neighbour has settled.
// Ports:
//   i_CLK : clock, rising edge
//   i_RST : synchronous active-high reset
//   bus   : systolic_pq_if.slave (request in, head/status out, all registered)
// -----------------------------------------------------------------------------
module systolic_pq #(
  parameter int QUEUE_SIZE = 16,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 16,
  parameter int MAX_FIRST  = 0
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  systolic_pq_if.slave bus
);
  localparam int CW = $clog2(QUEUE_SIZE + 1);

  localparam logic [1:0] OP_ENQ = 2'b00;
  localparam logic [1:0] OP_DEQ = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [KEY_WIDTH-1:0] EMPTY_KEY =
    (MAX_FIRST != 0) ? {KEY_WIDTH{1'b0}} : {KEY_WIDTH{1'b1}};
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_SIZE);

  typedef struct packed {
    logic                 vld;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } entry_t;

  // act: token present; ins: insertion (else removal); frc: displaced entry
  // that must take the cell unconditionally.
  typedef struct packed {
    logic   act;
    logic   ins;
    logic   frc;
    entry_t ent;
  } token_t;

  localparam entry_t EMPTY_ENT = {1'b0, EMPTY_KEY, {VAL_WIDTH{1'b0}}};
  localparam token_t IDLE_TOK  = {1'b0, 1'b0, 1'b0, EMPTY_ENT};

  // Strictly higher priority; ties never win, which keeps equal keys in
  // arrival order.
  function automatic logic ahead(input logic [KEY_WIDTH-1:0] a,
                                 input logic [KEY_WIDTH-1:0] b);
    if (MAX_FIRST != 0) begin
      ahead = (a > b);
    end else begin
      ahead = (a < b);
    end
  endfunction

  entry_t  cell_r     [QUEUE_SIZE];
  entry_t  cell_nxt_s [QUEUE_SIZE];
  entry_t  below_s    [QUEUE_SIZE];
  token_t  tin_s      [QUEUE_SIZE];
  token_t  tout_s     [QUEUE_SIZE];
  token_t  tok_r      [1:QUEUE_SIZE-1];
  token_t  head_tok_s;
  entry_t  new_ent_s;

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          drop_r;
  logic          drop_nxt_s;
  logic          ready_r;
  logic          ready_nxt_s;
  logic          accept_s;

  assign accept_s  = bus.i_op_valid & ready_r;
  assign new_ent_s = {1'b1, bus.i_key, bus.i_val};

  // Decode an accepted request into the token for cell 0 and the new status.
  always_comb begin
    head_tok_s  = IDLE_TOK;
    count_nxt_s = count_r;
    drop_nxt_s  = 1'b0;
    ready_nxt_s = 1'b1;
    if (accept_s) begin
      case (bus.i_op)
        OP_ENQ: begin
          ready_nxt_s = 1'b0;
          if (full_r) begin
            drop_nxt_s = 1'b1;
          end else begin
            head_tok_s  = {1'b1, 1'b1, 1'b0, new_ent_s};
            count_nxt_s = count_r + ONE_CNT;
          end
        end
        OP_DEQ: begin
          ready_nxt_s = 1'b0;
          if (empty_r) begin
            drop_nxt_s = 1'b1;
          end else begin
            head_tok_s  = {1'b1, 1'b0, 1'b0, EMPTY_ENT};
            count_nxt_s = count_r - ONE_CNT;
          end
        end
        OP_REP: begin
          ready_nxt_s = 1'b0;
          if (empty_r) begin
            head_tok_s  = {1'b1, 1'b1, 1'b0, new_ent_s};
            count_nxt_s = count_r + ONE_CNT;
          end else begin
            // Removal that carries the new entry: it sinks to its place.
            head_tok_s = {1'b1, 1'b0, 1'b0, new_ent_s};
          end
        end
        OP_NOP: begin
          ready_nxt_s = 1'b1;
        end
        default: begin
          ready_nxt_s = 1'b1;
        end
      endcase
    end else begin
      ready_nxt_s = 1'b1;
    end
  end

  for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_cell
    if (g == 0) begin : g_head
      assign tin_s[g] = head_tok_s;
    end else begin : g_body
      assign tin_s[g] = tok_r[g];
    end

    // The tail cell sees an empty neighbour below it.
    if (g < QUEUE_SIZE - 1) begin : g_mid
      assign below_s[g] = cell_r[g+1];
    end else begin : g_tail
      assign below_s[g] = EMPTY_ENT;
    end

    // Apply the token at this cell and form the token for the next cell.
    always_comb begin
      cell_nxt_s[g] = cell_r[g];
      tout_s[g]     = IDLE_TOK;
      if (tin_s[g].act) begin
        if (tin_s[g].ins) begin
          if (tin_s[g].frc || !cell_r[g].vld ||
              ahead(tin_s[g].ent.key, cell_r[g].key)) begin
            cell_nxt_s[g] = tin_s[g].ent;
            if (cell_r[g].vld) begin
              tout_s[g] = {1'b1, 1'b1, 1'b1, cell_r[g]};
            end else begin
              tout_s[g] = IDLE_TOK;
            end
          end else begin
            tout_s[g] = tin_s[g];
          end
        end else begin
          // Pull the neighbour up unless the carried entry belongs here;
          // an equal-key neighbour moves up so the carried entry lands behind it.
          if (below_s[g].vld &&
              (!tin_s[g].ent.vld || !ahead(tin_s[g].ent.key, below_s[g].key))) begin
            cell_nxt_s[g] = below_s[g];
            tout_s[g]     = tin_s[g];
          end else begin
            cell_nxt_s[g] = tin_s[g].ent;
            tout_s[g]     = IDLE_TOK;
          end
        end
      end else begin
        cell_nxt_s[g] = cell_r[g];
      end
    end
  end

  // Cell array, in-flight tokens and status registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        cell_r[i] <= EMPTY_ENT;
      end
      for (int i = 1; i < QUEUE_SIZE; i++) begin
        tok_r[i] <= IDLE_TOK;
      end
      count_r <= ZERO_CNT;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      drop_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        cell_r[i] <= cell_nxt_s[i];
      end
      for (int i = 1; i < QUEUE_SIZE; i++) begin
        tok_r[i] <= tout_s[i-1];
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == ZERO_CNT);
      drop_r  <= drop_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Empty cells hold the sentinel key and a zero payload, so the head cell
  // can drive the outputs directly.
  assign bus.o_key   = cell_r[0].key;
  assign bus.o_val   = cell_r[0].val;
  assign bus.o_count = count_r;
  assign bus.o_full  = full_r;
  assign bus.o_empty = empty_r;
  assign bus.o_drop  = drop_r;
  assign bus.o_ready = ready_r;
endmodule

// File: tb/tb_systolic_pq.sv
module tb_systolic_pq;
  localparam int QS = 4;
  localparam int KW = 16;
  localparam int VW = 16;
  localparam int CW = $clog2(QS + 1);
  localparam int OW = KW + VW + CW + 3;
  localparam logic [1:0] ENQ = 2'b00;
  localparam logic [1:0] DEQ = 2'b01;
  localparam logic [1:0] REP = 2'b10;
  localparam logic [1:0] NOP = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  systolic_pq_if #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .CNT_WIDTH(CW)) bmin ();
  systolic_pq_if #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .CNT_WIDTH(CW)) bmax ();

  systolic_pq #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_FIRST(0)) dut_min (
    .i_CLK(clk), .i_RST(rst), .bus(bmin));
  systolic_pq #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_FIRST(1)) dut_max (
    .i_CLK(clk), .i_RST(rst), .bus(bmax));

  assign bmax.i_op_valid = bmin.i_op_valid;
  assign bmax.i_op       = bmin.i_op;
  assign bmax.i_key      = bmin.i_key;
  assign bmax.i_val      = bmin.i_val;

  always #5 clk = ~clk;

  // Reference model: per mode (0 = min, 1 = max) a sorted array, head at 0.
  logic [KW-1:0] mk [2][QS];
  logic [VW-1:0] mv [2][QS];
  int mn [2];

  function automatic bit m_before(int m, logic [KW-1:0] a, logic [KW-1:0] b);
    return (m == 1) ? (a > b) : (a < b);
  endfunction

  function automatic void m_insert(int m, logic [KW-1:0] k, logic [VW-1:0] v);
    int p = mn[m];
    for (int i = 0; i < mn[m]; i++)
      if (p == mn[m] && m_before(m, k, mk[m][i])) p = i;
    for (int i = mn[m]; i > p; i--) begin
      mk[m][i] = mk[m][i-1];
      mv[m][i] = mv[m][i-1];
    end
    mk[m][p] = k;
    mv[m][p] = v;
    mn[m]++;
  endfunction

  function automatic void m_remove(int m);
    for (int i = 0; i < mn[m] - 1; i++) begin
      mk[m][i] = mk[m][i+1];
      mv[m][i] = mv[m][i+1];
    end
    mn[m]--;
  endfunction

  function automatic bit m_apply(int m, logic [1:0] op, logic [KW-1:0] k, logic [VW-1:0] v);
    bit d = 1'b0;
    case (op)
      ENQ: if (mn[m] == QS) d = 1'b1; else m_insert(m, k, v);
      DEQ: if (mn[m] == 0) d = 1'b1; else m_remove(m);
      REP: begin
        if (mn[m] != 0) m_remove(m);
        m_insert(m, k, v);
      end
      default: d = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [OW-1:0] exp_vec(int m, bit drop);
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    if (mn[m] == 0) begin
      k = (m == 1) ? {KW{1'b0}} : {KW{1'b1}};
      v = {VW{1'b0}};
    end else begin
      k = mk[m][0];
      v = mv[m][0];
    end
    return {k, v, CW'(mn[m]), (mn[m] == QS), (mn[m] == 0), drop};
  endfunction

  function automatic logic [OW-1:0] obs_vec(int m);
    if (m == 0)
      return {bmin.o_key, bmin.o_val, bmin.o_count, bmin.o_full, bmin.o_empty, bmin.o_drop};
    else
      return {bmax.o_key, bmax.o_val, bmax.o_count, bmax.o_full, bmax.o_empty, bmax.o_drop};
  endfunction

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic do_op(input logic [1:0] op, input logic [KW-1:0] k,
                       input logic [VW-1:0] v, output bit d);
    int w = 0;
    while (bmin.o_ready !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (w >= 16) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got o_ready=%b want 1", bmin.o_ready);
    end
    bmin.i_op_valid = 1'b1;
    bmin.i_op = op;
    bmin.i_key = k;
    bmin.i_val = v;
    @(posedge clk);
    d = m_apply(0, op, k, v);
    void'(m_apply(1, op, k, v));
    @(negedge clk);
    bmin.i_op_valid = 1'b0;
    bmin.i_key = $urandom;
    bmin.i_val = $urandom;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mn[0] = 0;
    mn[1] = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mn[0] = 0;
    mn[1] = 0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_vec(m) !== exp_vec(m, 1'b0)) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h want %h", m, obs_vec(m), exp_vec(m, 1'b0));
      end
    end
    checks++;
    if ({bmin.o_ready, bmax.o_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b want 00", {bmin.o_ready, bmax.o_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bmin.o_ready, bmax.o_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 11", {bmin.o_ready, bmax.o_ready});
    end
  endtask

  task automatic test_ordering();
    logic [KW-1:0] keys [4];
    logic [KW-1:0] heads [4];
    logic [KW-1:0] dk [4];
    logic [VW-1:0] dv [4];
    bit d;
    keys  = '{16'd7, 16'd3, 16'd9, 16'd3};
    heads = '{16'd7, 16'd3, 16'd3, 16'd3};
    dk    = '{16'd3, 16'd3, 16'd7, 16'd9};
    dv    = '{16'd2, 16'd4, 16'd1, 16'd3};
    for (int i = 0; i < 4; i++) begin
      do_op(ENQ, keys[i], VW'(i + 1), d);
      checks++;
      if (bmin.o_key !== heads[i] || bmin.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL enq_head[%0d] got key %0d ready %b want key %0d ready 0",
                 i, bmin.o_key, bmin.o_ready, heads[i]);
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_vec(m) !== exp_vec(m, d)) begin
          errors++;
          $display("FAIL enq_model[%0d] dut%0d got %h want %h", i, m, obs_vec(m), exp_vec(m, d));
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bmin.o_key, bmin.o_val} !== {dk[i], dv[i]}) begin
        errors++;
        $display("FAIL deq_head[%0d] got (%0d,%0d) want (%0d,%0d)",
                 i, bmin.o_key, bmin.o_val, dk[i], dv[i]);
      end
      do_op(DEQ, 16'd0, 16'd0, d);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_vec(m) !== exp_vec(m, d)) begin
          errors++;
          $display("FAIL deq_model[%0d] dut%0d got %h want %h", i, m, obs_vec(m), exp_vec(m, d));
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({bmin.o_empty, bmin.o_key} !== {1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL drained got empty %b key %h want empty 1 key ffff", bmin.o_empty, bmin.o_key);
    end
  endtask

  task automatic test_full_empty();
    bit d;
    for (int i = 1; i <= 4; i++) begin
      do_op(ENQ, KW'(i), VW'(16 + i), d);
      @(negedge clk);
    end
    checks++;
    if ({bmin.o_full, bmin.o_count} !== {1'b1, CW'(4)}) begin
      errors++;
      $display("FAIL full_flag got full %b count %0d want full 1 count 4", bmin.o_full, bmin.o_count);
    end
    do_op(ENQ, 16'd0, 16'd99, d);
    checks++;
    if ({bmin.o_drop, bmin.o_key, bmin.o_count, d} !== {1'b1, 16'd1, CW'(4), 1'b1}) begin
      errors++;
      $display("FAIL enq_full_drop got drop %b key %0d count %0d want drop 1 key 1 count 4",
               bmin.o_drop, bmin.o_key, bmin.o_count);
    end
    @(negedge clk);
    checks++;
    if (bmin.o_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse_width got %b want 0", bmin.o_drop);
    end
    do_op(REP, 16'd10, 16'd77, d);
    checks++;
    if ({bmin.o_key, bmin.o_count, bmin.o_drop} !== {16'd2, CW'(4), 1'b0}) begin
      errors++;
      $display("FAIL replace_full got key %0d count %0d drop %b want key 2 count 4 drop 0",
               bmin.o_key, bmin.o_count, bmin.o_drop);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_vec(m) !== exp_vec(m, d)) begin
        errors++;
        $display("FAIL replace_model dut%0d got %h want %h", m, obs_vec(m), exp_vec(m, d));
      end
    end
    @(negedge clk);
    repeat (3) begin
      do_op(DEQ, 16'd0, 16'd0, d);
      @(negedge clk);
    end
    checks++;
    if ({bmin.o_key, bmin.o_val} !== {16'd10, 16'd77}) begin
      errors++;
      $display("FAIL tail_entry got (%0d,%0d) want (10,77)", bmin.o_key, bmin.o_val);
    end
    do_op(DEQ, 16'd0, 16'd0, d);
    @(negedge clk);
    do_op(DEQ, 16'd0, 16'd0, d);
    checks++;
    if ({bmin.o_drop, bmin.o_count, bmin.o_empty} !== {1'b1, CW'(0), 1'b1}) begin
      errors++;
      $display("FAIL deq_empty_drop got drop %b count %0d empty %b want 1 0 1",
               bmin.o_drop, bmin.o_count, bmin.o_empty);
    end
    @(negedge clk);
    do_op(REP, 16'd5, 16'd55, d);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({obs_vec(m), d} !== {exp_vec(m, 1'b0), 1'b0} ||
          {obs_vec(m) >> (VW + CW + 3)} !== OW'(16'd5)) begin
        errors++;
        $display("FAIL replace_empty dut%0d got %h want %h", m, obs_vec(m), exp_vec(m, 1'b0));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit exp_rdy = 1'b1;
    bit acc;
    bit d;
    int accepted = 0;
    logic [1:0] op;
    for (int c = 0; c < 16; c++) begin
      op = 2'($urandom_range(0, 2));
      bmin.i_op_valid = 1'b1;
      bmin.i_op = op;
      bmin.i_key = ($urandom_range(0, 3) == 0) ? 16'hFFFF : KW'($urandom_range(0, 5));
      bmin.i_val = VW'($urandom);
      acc = exp_rdy;
      @(posedge clk);
      d = 1'b0;
      if (acc) begin
        accepted++;
        d = m_apply(0, op, bmin.i_key, bmin.i_val);
        void'(m_apply(1, op, bmin.i_key, bmin.i_val));
      end
      exp_rdy = !acc;
      @(negedge clk);
      checks++;
      if (bmin.o_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b want %b", c, bmin.o_ready, exp_rdy);
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_vec(m) !== exp_vec(m, d)) begin
          errors++;
          $display("FAIL b2b_model[%0d] dut%0d got %h want %h", c, m, obs_vec(m), exp_vec(m, d));
        end
      end
    end
    bmin.i_op_valid = 1'b0;
    checks++;
    if (accepted != 8) begin
      errors++;
      $display("FAIL b2b_accept_count got %0d want 8", accepted);
    end
    @(negedge clk);
    do_op(NOP, 16'd1, 16'd1, d);
    checks++;
    if ({bmin.o_ready, obs_vec(0)} !== {1'b1, exp_vec(0, 1'b0)}) begin
      errors++;
      $display("FAIL nop got ready %b state %h want ready 1 state %h",
               bmin.o_ready, obs_vec(0), exp_vec(0, 1'b0));
    end
  endtask

  task automatic test_max_mode();
    logic [KW-1:0] keys [3];
    logic [KW-1:0] heads [3];
    bit d;
    keys  = '{16'd0, 16'hFFFF, 16'd5};
    heads = '{16'd0, 16'hFFFF, 16'hFFFF};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_op(ENQ, keys[i], VW'(i + 1), d);
      checks++;
      if (bmax.o_key !== heads[i] || obs_vec(1) !== exp_vec(1, d)) begin
        errors++;
        $display("FAIL max_enq[%0d] got key %h want %h", i, bmax.o_key, heads[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bmax.o_key !== keys[(i == 0) ? 1 : (i == 1) ? 2 : 0]) begin
        errors++;
        $display("FAIL max_deq[%0d] got key %h", i, bmax.o_key);
      end
      do_op(DEQ, 16'd0, 16'd0, d);
      @(negedge clk);
    end
    checks++;
    if ({bmax.o_count, bmax.o_empty, bmax.o_key} !== {CW'(0), 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL max_drained got count %0d empty %b key %h want 0 1 0000",
               bmax.o_count, bmax.o_empty, bmax.o_key);
    end
  endtask

  task automatic test_reset_mid();
    bit d;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_op(ENQ, KW'($urandom_range(0, 100)), VW'(i), d);
      @(negedge clk);
    end
    do_op(ENQ, 16'd1, 16'd1, d);
    rst = 1'b1;
    @(negedge clk);
    mn[0] = 0;
    mn[1] = 0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_vec(m) !== exp_vec(m, 1'b0)) begin
        errors++;
        $display("FAIL mid_reset_state dut%0d got %h want %h", m, obs_vec(m), exp_vec(m, 1'b0));
      end
    end
    checks++;
    if (bmin.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready got %b want 0", bmin.o_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bmin.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_recover got %b want 1", bmin.o_ready);
    end
    do_op(ENQ, 16'd42, 16'd7, d);
    repeat (QS) @(negedge clk);
    do_op(DEQ, 16'd0, 16'd0, d);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_vec(m) !== exp_vec(m, d)) begin
        errors++;
        $display("FAIL mid_reset_clean dut%0d got %h want %h", m, obs_vec(m), exp_vec(m, d));
      end
    end
  endtask

  initial begin
    bmin.i_op_valid = 1'b0;
    bmin.i_op = NOP;
    bmin.i_key = 16'd0;
    bmin.i_val = 16'd0;
    mn[0] = 0;
    mn[1] = 0;
    test_reset();
    test_ordering();
    test_full_empty();
    test_back_to_back();
    test_max_mode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/systolic_pq.md
SYSTOLIC_PQ -- requirements
Module: systolic_pq

Interface
REQ-001 Parameter QUEUE_SIZE, default 16: number of systolic cells, i.e. maximum stored entries; even and >=2.
REQ-002 Parameter KEY_WIDTH, default 16: priority key width in bits.
REQ-003 Parameter VAL_WIDTH, default 16: payload width in bits.
REQ-004 Parameter MAX_FIRST, default 0: 0 = min-queue, smallest key at head; 1 = max-queue, largest key at head.
REQ-005 i_CLK  input  1  sole clock; all state changes on the rising edge.
REQ-006 i_RST  input  1  reset; synchronous, active-high.
REQ-007 i_op_valid  input  1  operation request, qualified by o_ready.
REQ-008 i_op  input  2  operation code: 00 ENQUEUE, 01 DEQUEUE, 10 REPLACE, 11 NOP.
REQ-009 i_key  input  KEY_WIDTH  key for ENQUEUE or REPLACE.
REQ-010 i_val  input  VAL_WIDTH  payload for ENQUEUE or REPLACE.
REQ-011 o_ready  output  1  high when an operation can be accepted this cycle.
REQ-012 o_key  output  KEY_WIDTH  head key (registered).
REQ-013 o_val  output  VAL_WIDTH  head payload (registered).
REQ-014 o_count  output  $clog2(QUEUE_SIZE+1)  number of stored entries.
REQ-015 o_full  output  1  o_count == QUEUE_SIZE.
REQ-016 o_empty  output  1  o_count == 0.
REQ-017 o_drop  output  1  one-cycle pulse: an accepted operation was illegal and discarded.

Function
REQ-018 Accept rule: an operation is accepted on a rising edge where i_op_valid=1 and o_ready=1. Requests seen while o_ready=0 have no effect and do not raise o_drop.
REQ-019 o_ready goes to 0 for exactly one cycle after each accepted non-NOP operation. The maximum rate is therefore one operation every 2 cycles.
REQ-020 An accepted NOP has no effect and leaves o_ready at 1.
REQ-021 Storage is a linear array of QUEUE_SIZE cells.
- Cell 0 is the head.
- Each cell compares only with its neighbours.
- No global broadcast is allowed beyond the op/key/val inputs into cell 0.
REQ-022 ENQUEUE when not full:
- the new entry is inserted in priority order;
- the displaced lower-priority entries ripple one cell per cycle toward the tail.
REQ-023 DEQUEUE when not empty:
- the head is removed;
- the next entry moves into cell 0;
- the vacancy ripples toward the tail.
REQ-024 REPLACE when not empty is an atomic removal of the head plus insertion of (i_key, i_val); o_count is unchanged.
REQ-025 REPLACE when empty behaves as ENQUEUE.
REQ-026 ENQUEUE when full is discarded: state unchanged, o_drop=1 for one cycle, o_ready still deasserts per REQ-019.
REQ-027 DEQUEUE when empty is discarded in the same way, with o_drop=1.
REQ-028 Ordering is stable: entries with equal keys leave in arrival order, and a new entry is placed behind all existing equal-key entries.
REQ-029 Key comparison is unsigned. The payload never affects ordering.
REQ-030 Head latency: o_key/o_val/o_count/o_full/o_empty reflect the accepted operation from the rising edge that accepts it. They are valid in the following cycle.
REQ-031 Consistency: after the single o_ready=0 cycle, the whole array is ordered, so any sequence of accepted operations yields the correct head every cycle o_ready=1.
REQ-032 When empty:
- o_key = all ones if MAX_FIRST=0;
- o_key = all zeros if MAX_FIRST=1;
- o_val = 0.
REQ-033 Empty cells act as sentinels holding the empty key of REQ-032. A valid entry whose key equals the sentinel value must still be counted and ordered ahead of empty cells, using a per-cell valid bit.
REQ-034 i_key/i_val are sampled only on the accepting edge.

Reset
REQ-035 While i_RST=1 at a rising edge:
- all cells are invalidated;
- o_count=0, o_empty=1, o_full=0, o_drop=0, o_ready=0;
- o_key/o_val take the empty values of REQ-032.
REQ-036 o_ready=1 in the first cycle after a rising edge with i_RST=0.
REQ-037 Reset asserted mid-ripple discards all in-flight movement. No partial state survives.

Verification
REQ-038 Parameters QUEUE_SIZE=4, MIN mode; enqueue 7, 3, 9, 3 (tagged vals 1,2,3,4) at one per 2 cycles.
- Required head after each: 7, 3, 3, 3.
- Then dequeue four times: (key,val) = (3,2), (3,4), (7,1), (9,3).
- Finally o_empty=1, o_key=0xFFFF.
REQ-039 Full queue {1,2,3,4}: ENQUEUE 0 -> o_drop pulse, head stays 1, o_count=4. REPLACE 10 -> head 2, o_count=4, tail holds 10.
REQ-040 Empty queue: DEQUEUE -> o_drop pulse, o_count=0. REPLACE key 5 -> head 5, o_count=1.
REQ-041 Back-to-back requests held every cycle: only alternate cycles accepted. 8 random mixed ops checked against a sorted stable reference model every o_ready cycle.
REQ-042 MAX_FIRST=1: enqueue 0, 0xFFFF, 5 -> heads 0, 0xFFFF, 0xFFFF. Dequeues yield 0xFFFF, 5, 0; o_count reaches 0.
REQ-043 Assert i_RST for one cycle with 3 entries and an ENQUEUE accepted the cycle before -> next cycle o_count=0, o_empty=1, o_ready=0, then o_ready=1.
